// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the fetch PC, drives a 1-cycle-latency
// instruction memory, and buffers returned instructions in a 2-entry FIFO
// presented to decode over valid/ready. Fetch issue is credit-limited so
// that every in-flight response always has a FIFO slot to land in.
// A redirect flushes the FIFO and squashes any response that lands in the
// same cycle. Responses are tagged with the epoch current at issue, and a
// response whose epoch no longer matches is dropped.
module fetch_stage #(
    parameter int PC_W     = 10,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               br_valid,
    input  logic [PC_W-1:0]    br_target,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    input  logic               id_ready
);

    localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);

    logic [PC_W-1:0]    fpc_q, fpc_d;
    logic               inflight_q, inflight_d;
    logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
    logic               inflight_epoch_q, inflight_epoch_d;
    logic               epoch_q, epoch_d;
    logic [1:0]         count_q, count_d;
    logic [INSTR_W-1:0] instr0_q, instr0_d, instr1_q, instr1_d;
    logic [PC_W-1:0]    pc0_q, pc0_d, pc1_q, pc1_d;

    logic               pop;
    logic               issue;
    logic               resp_ok;
    logic [2:0]         credit_used;
    logic [1:0]         cnt_after_pop;

    // Decode handshake, credit-limited issue and response qualification
    always_comb begin
        if_valid    = (count_q != 2'd0) && !br_valid;
        if_instr    = (count_q != 2'd0) ? instr0_q : '0;
        if_pc       = (count_q != 2'd0) ? pc0_q : '0;
        pop         = if_valid && id_ready;
        // Slots that are occupied after this cycle's pop, counting the response still owed
        credit_used = 3'(count_q) - 3'(pop) + 3'(inflight_q);
        issue       = en && !br_valid && !reset && (credit_used < 3'd2);
        imem_en     = issue;
        imem_addr   = fpc_q;
        resp_ok     = inflight_q && (inflight_epoch_q == epoch_q) && !br_valid;
    end

    // Next-state: fetch PC, in-flight tracking and FIFO update
    always_comb begin
        fpc_d            = fpc_q;
        inflight_d       = issue;
        inflight_pc_d    = inflight_pc_q;
        inflight_epoch_d = inflight_epoch_q;
        epoch_d          = epoch_q;
        count_d          = count_q;
        instr0_d         = instr0_q;
        instr1_d         = instr1_q;
        pc0_d            = pc0_q;
        pc1_d            = pc1_q;
        cnt_after_pop    = count_q - 2'(pop);

        if (issue) begin
            fpc_d            = fpc_q + PC_W'(1);
            inflight_pc_d    = fpc_q;
            inflight_epoch_d = epoch_q;
        end

        if (br_valid) begin
            // Redirect wins over pop and response write; issue is already blocked
            count_d = 2'd0;
            fpc_d   = br_target;
            epoch_d = ~epoch_q;
        end else begin
            if (pop) begin
                instr0_d = instr1_q;
                pc0_d    = pc1_q;
            end
            if (resp_ok) begin
                if (cnt_after_pop == 2'd0) begin
                    instr0_d = imem_rdata;
                    pc0_d    = inflight_pc_q;
                end else begin
                    instr1_d = imem_rdata;
                    pc1_d    = inflight_pc_q;
                end
                count_d = cnt_after_pop + 2'd1;
            end else begin
                count_d = cnt_after_pop;
            end
        end
    end

    // State registers with synchronous reset; reset also drops any in-flight response
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q            <= RESET_PC_V;
            inflight_q       <= 1'b0;
            inflight_pc_q    <= '0;
            inflight_epoch_q <= 1'b0;
            epoch_q          <= 1'b0;
            count_q          <= 2'd0;
            instr0_q         <= '0;
            instr1_q         <= '0;
            pc0_q            <= '0;
            pc1_q            <= '0;
        end else begin
            fpc_q            <= fpc_d;
            inflight_q       <= inflight_d;
            inflight_pc_q    <= inflight_pc_d;
            inflight_epoch_q <= inflight_epoch_d;
            epoch_q          <= epoch_d;
            count_q          <= count_d;
            instr0_q         <= instr0_d;
            instr1_q         <= instr1_d;
            pc0_q            <= pc0_d;
            pc1_q            <= pc1_d;
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage directly downstream of the PC counter. Owns the fetch PC, drives the synchronous instruction memory (1-cycle read latency), and buffers returned instructions in a 2-entry FIFO. Presents {instr, pc} to decode over a valid/ready handshake. Handles branch redirect with flush and in-flight squash, and supports back-pressure without losing or duplicating instructions.

Parameters:
PC_W, 10, fetch PC / imem address width
INSTR_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high
en  in  1  fetch enable; 0 = issue no new fetches (responses in flight still land)
imem_en  out  1  read strobe to instruction memory
imem_addr  out  PC_W  read address (= fetch PC)
imem_rdata  in  INSTR_W  read data, valid the cycle after imem_en=1
br_valid  in  1  redirect request from execute
br_target  in  PC_W  redirect target PC
if_valid  out  1  instruction available to decode
if_instr  out  INSTR_W  head instruction
if_pc  out  PC_W  PC of head instruction
id_ready  in  1  decode accepts head this cycle

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock clk.
- State: fpc (fetch PC); inflight flag plus inflight_pc; 2-entry FIFO of {instr, pc} with count 0..2; epoch bit.
- Reset values: fpc=RESET_PC, inflight=0, count=0, epoch=0. Outputs imem_en=0, if_valid=0, if_instr=0, if_pc=0. Reset mid-operation discards the FIFO and any in-flight response. The response arriving in the cycle after reset is ignored.
- Pop: pop = if_valid & id_ready.
- Issue rule (combinational): imem_en = en & ~br_valid & ~reset & ((count - pop) + inflight < 2). imem_addr = fpc.
- On issue: fpc <= fpc+1, modulo 2^PC_W (1023 -> 0 for PC_W=10). Also inflight <= 1, inflight_pc <= fpc.
- With no issue: inflight <= 0.
- Response: when inflight=1 and the response was not squashed, {imem_rdata, inflight_pc} is written to the FIFO tail at the clock edge. The credit rule guarantees space, so overflow cannot occur.
- Head output: if_instr/if_pc show the FIFO head when count>0. They are held stable while if_valid=1 and id_ready=0.
- if_valid: if_valid = (count>0) & ~br_valid.
- Latency: fetch issued in cycle N -> data in FIFO at edge ending N+1 -> if_valid in cycle N+2 (FIFO previously empty).
- Steady state: with id_ready=1 and en=1, one instruction per cycle and consecutive PCs.
- Redirect (br_valid=1 in cycle B): highest priority, overrides en, pop and response write.
  - At the edge: count<=0, fpc<=br_target, epoch toggles, and any response due in B+1 is discarded. The epoch is tagged on issue and compared on return.
  - No fetch is issued in cycle B. The target is fetched in B+1, and its if_valid is first seen in B+3.
  - A br_valid held over consecutive cycles uses the last target.
- en=0: no issue. The in-flight response still lands and the FIFO still drains. Re-asserting en resumes at fpc with no gap or duplicate.
- Simultaneous pop and response with count=2 cannot occur (credit rule). With count=1, pop+write leaves count=1 with the new entry at the head.
- Ordering: instructions leave in strict PC order between redirects. Nothing is dropped or duplicated under any id_ready pattern.

Test Plan:
- Reset release, en=1, id_ready=1, imem returns {22'b0, addr}: if_valid first high 2 cycles after reset falls. if_pc = 0,1,2,3... on consecutive cycles, with if_instr matching.
- id_ready=0 for 5 cycles mid-stream: at most 2 entries buffered, imem_en drops, if_pc/if_instr held. On release, PCs continue with no gap or duplicate.
- br_valid with br_target=0x200 while a fetch is in flight and count=2: if_valid=0 in cycle B. No stale PC is ever output. if_pc=0x200 first valid in B+3, then 0x201.
- fpc at 0x3FE, free-running: emitted PCs are 0x3FE, 0x3FF, 0x000, 0x001.
- en toggled low for 3 cycles, then high: in-flight instruction is still delivered. Sequence resumes at the next PC and imem_addr never repeats.
- Reset asserted with count=2 and a fetch in flight: the next cycle shows if_valid=0. After release, the sequence restarts at RESET_PC and the pre-reset response is never delivered.
